// File: rtl/alu_cmd_sequencer.sv
// Streams buffered commands into the combinational 5-bit ALU; result valid SETTLE+1 cycles after issue.
// cmd_ready drops while the FIFO is full or in reset; a captured result holds until res_ready.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [4:0]               cmd_a,
  input  logic [4:0]               cmd_b,
  input  logic [1:0]               cmd_sel,
  output logic [4:0]               alu_a,
  output logic [4:0]               alu_b,
  output logic [1:0]               alu_sel,
  input  logic [4:0]               alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [4:0]               res_data,
  output logic [1:0]               res_sel,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_t;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] sel;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]    alu_sel_q, alu_sel_d;
  logic          res_valid_q, res_valid_d;
  logic [4:0]    res_data_q, res_data_d;
  logic [1:0]    res_sel_q, res_sel_d;
  logic          push, pop, full;

  // No pass-through: a full FIFO refuses even when a pop happens on the same edge.
  assign full      = (level_q == LW'(DEPTH));
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_sel};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop       = 1'b1;
          alu_a_d   = head.a;
          alu_b_d   = head.b;
          alu_sel_d = head.sel;
          cnt_d     = CW'(SETTLE - 1);
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_data_d  = alu_out;
          res_sel_d   = alu_sel_q;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          // Back-to-back issue: the next command is loaded on the handshake edge.
          if (level_q != '0) begin
            pop       = 1'b1;
            alu_a_d   = head.a;
            alu_b_d   = head.b;
            alu_sel_d = head.sel;
            cnt_d     = CW'(SETTLE - 1);
            state_d   = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_sel   = res_sel_q;
  assign level     = level_q;
  assign busy      = (state_q != IDLE) || (level_q != '0);

endmodule
